// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the programmable synchronous FIFO.
// Read-mode constants and wrapping pointer arithmetic.
package sync_fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH simple dual-port storage.
// Read port is registered in standard mode, combinational in FWFT mode.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  if (FWFT == FIFO_FWFT) begin : g_async
    logic unused_rd;
    assign unused_rd = rst ^ re_i;
    assign rdata_o   = mem_q[raddr_i];
  end else begin : g_sync
    logic [WIDTH-1:0] rdata_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with arbitrary depth, optional FWFT, thresholds,
// sticky error flags, peak watermark and pass-through write when full.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             empty,
  output logic             almost_empty,
  output logic             underflow,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] peak,
  input  logic             clr_stat
);

  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2 || WIDTH < 1) begin : g_bad_size
    $fatal(1, "sync_fifo_prog: DEPTH must be >=2 and WIDTH >=1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thr
    $fatal(1, "sync_fifo_prog: threshold out of range");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] peak_q, peak_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             rd_accept, wr_accept;

  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));

  assign rd_accept = rd_en & ~empty;
  assign wr_accept = wr_en & (~full | rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    peak_d   = peak_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (wr_accept) begin
      wr_ptr_d = PW'(ptr_inc(int'(wr_ptr_q), DEPTH));
    end
    if (rd_accept) begin
      rd_ptr_d = PW'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end
    unique case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (clr_stat) begin
      peak_d = count_d;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else if (count_d > peak_q) begin
      peak_d = count_d;
    end
    // An error in the same cycle as clr_stat keeps its flag set.
    if (wr_en & ~wr_accept) ovf_d = 1'b1;
    if (rd_en & empty)      udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign count     = count_q;
  assign peak      = peak_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .FWFT  (FWFT),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (rd_accept),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rd_valid = ~empty;
  end else begin : g_std
    logic rv_q;
    always_ff @(posedge clk) begin
      if (rst) rv_q <= 1'b0;
      else     rv_q <= rd_accept;
    end
    assign rd_valid = rv_q;
  end

endmodule
